// File: rtl/multi_hart_timer_pkg.sv
// Shared definitions for the multi-hart timer: register map, channel modes and
// the per-channel write-strobe bundle.
package multi_hart_timer_pkg;

  localparam logic [11:0] RegCtrl    = 12'h000;
  localparam logic [11:0] RegCfg     = 12'h004;
  localparam logic [11:0] RegMtimeLo = 12'h008;
  localparam logic [11:0] RegMtimeHi = 12'h00C;

  localparam logic [11:0] HartBase   = 12'h100;
  localparam logic [11:0] HartStride = 12'h020;
  localparam int          HartShift  = 5;

  localparam logic [4:0] ChCmpLo  = 5'h00;
  localparam logic [4:0] ChCmpHi  = 5'h04;
  localparam logic [4:0] ChPeriod = 5'h08;
  localparam logic [4:0] ChCtrl   = 5'h0C;
  localparam logic [4:0] ChStatus = 5'h10;

  localparam int ChctrlEnBit   = 0;
  localparam int ChctrlModeLsb = 1;
  localparam int CfgStepLsb    = 16;

  typedef enum logic [1:0] {
    MODE_LEVEL    = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_ONESHOT  = 2'd2
  } mode_e;

  typedef struct packed {
    logic cmp_lo;
    logic cmp_hi;
    logic period;
    logic chctrl;
    logic status;
  } ch_wr_t;

endpackage

// File: rtl/timer_hart_channel.sv
// One compare channel: owns cmp/period/en/mode/pending, compares against the
// shared mtime and produces a registered interrupt level.
module timer_hart_channel
  import multi_hart_timer_pkg::*;
#(
  parameter int CounterWidth = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CounterWidth-1:0] mtime,
  input  ch_wr_t                  wr,
  input  logic [31:0]             wdata,
  input  logic [4:0]              rd_off,
  output logic [31:0]             rdata,
  output logic                    irq
);

  logic [CounterWidth-1:0] cmp;
  logic [31:0]             period;
  logic                    en;
  logic [1:0]              mode;
  logic                    pending;

  logic [63:0] cmp_ext;
  logic        match, fire, is_periodic, is_oneshot;

  assign cmp_ext     = 64'(cmp);
  assign match       = (mtime >= cmp);
  assign fire        = en & match;
  assign is_periodic = (mode == MODE_PERIODIC);
  assign is_oneshot  = (mode == MODE_ONESHOT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp     <= '1;
      period  <= '0;
      en      <= 1'b0;
      mode    <= MODE_LEVEL;
      pending <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= pending;

      // software writes take priority over the hardware reload
      if (wr.cmp_lo)
        cmp <= CounterWidth'({cmp_ext[63:32], wdata});
      else if (wr.cmp_hi)
        cmp <= CounterWidth'({wdata, cmp_ext[31:0]});
      else if (fire && is_periodic)
        cmp <= cmp + CounterWidth'(period);

      if (wr.period)
        period <= wdata;

      if (wr.chctrl) begin
        en   <= wdata[ChctrlEnBit];
        mode <= wdata[ChctrlModeLsb +: 2];
      end else if (fire && is_oneshot) begin
        en <= 1'b0;
      end

      // level (and reserved) mode tracks the match; others latch until W1C,
      // with a same-cycle fire beating the clear
      if (!(is_periodic || is_oneshot))
        pending <= fire;
      else if (fire)
        pending <= 1'b1;
      else if (wr.status && wdata[0])
        pending <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (rd_off)
      ChCmpLo:  rdata = cmp_ext[31:0];
      ChCmpHi:  rdata = cmp_ext[63:32];
      ChPeriod: rdata = period;
      ChCtrl:   rdata = {29'd0, mode, en};
      ChStatus: rdata = {31'd0, pending};
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/multi_hart_timer.sv
// Shared mtime with prescaler/step plus NumHarts compare channels, behind a
// simple single-cycle register port.
module multi_hart_timer
  import multi_hart_timer_pkg::*;
#(
  parameter int NumHarts      = 4,
  parameter int CounterWidth  = 64,
  parameter int PrescaleWidth = 12,
  parameter int StepWidth     = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [11:0]         addr_i,
  input  logic [31:0]         wdata_i,
  output logic                rvalid_o,
  output logic [31:0]         rdata_o,
  output logic                err_o,
  output logic [NumHarts-1:0] irq_o
);

  logic                     active;
  logic [PrescaleWidth-1:0] prescale;
  logic [PrescaleWidth-1:0] pcount;
  logic [StepWidth-1:0]     step;
  logic [CounterWidth-1:0]  mtime;
  logic [31:0]              shadow_hi;

  logic [63:0]              mtime_ext;
  logic                     tick;
  logic                     wr_en, rd_en;
  logic [11:0]              rel;
  logic [11-HartShift:0]    hart_idx;
  logic [HartShift-1:0]     ch_off;
  logic                     in_hart, glob_hit, ch_hit, hit;
  logic [31:0]              cfg_rd, rd_mux;

  ch_wr_t [NumHarts-1:0]      ch_wr;
  logic   [NumHarts-1:0][31:0] ch_rdata;

  assign mtime_ext = 64'(mtime);
  assign tick      = (pcount == prescale);
  assign wr_en     = req_i & we_i;
  assign rd_en     = req_i & ~we_i;

  // Address decode: four global words, then one 0x20 window per hart
  assign rel      = addr_i - HartBase;
  assign hart_idx = rel[11:HartShift];
  assign ch_off   = rel[HartShift-1:0];
  assign in_hart  = (addr_i >= HartBase) && (int'(hart_idx) < NumHarts);
  assign glob_hit = addr_i inside {RegCtrl, RegCfg, RegMtimeLo, RegMtimeHi};
  assign ch_hit   = in_hart && (ch_off inside {ChCmpLo, ChCmpHi, ChPeriod, ChCtrl, ChStatus});
  assign hit      = glob_hit | ch_hit;

  always_comb begin
    for (int h = 0; h < NumHarts; h++) begin
      ch_wr[h] = '0;
      if (wr_en && ch_hit && int'(hart_idx) == h) begin
        case (ch_off)
          ChCmpLo:  ch_wr[h].cmp_lo = 1'b1;
          ChCmpHi:  ch_wr[h].cmp_hi = 1'b1;
          ChPeriod: ch_wr[h].period = 1'b1;
          ChCtrl:   ch_wr[h].chctrl = 1'b1;
          ChStatus: ch_wr[h].status = 1'b1;
          default:  ch_wr[h] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active    <= 1'b0;
      prescale  <= '0;
      pcount    <= '0;
      step      <= StepWidth'(1);
      mtime     <= '0;
      shadow_hi <= '0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      if (wr_en && addr_i == RegCfg)
        pcount <= '0;
      else if (tick)
        pcount <= '0;
      else
        pcount <= pcount + PrescaleWidth'(1);

      if (wr_en && addr_i == RegCtrl)
        active <= wdata_i[0];

      if (wr_en && addr_i == RegCfg) begin
        prescale <= wdata_i[PrescaleWidth-1:0];
        step     <= wdata_i[CfgStepLsb +: StepWidth];
      end

      // a software write to either half suppresses that cycle's increment
      if (wr_en && addr_i == RegMtimeLo)
        mtime <= CounterWidth'({mtime_ext[63:32], wdata_i});
      else if (wr_en && addr_i == RegMtimeHi)
        mtime <= CounterWidth'({wdata_i, mtime_ext[31:0]});
      else if (tick && active)
        mtime <= mtime + CounterWidth'(step);

      if (rd_en && addr_i == RegMtimeLo)
        shadow_hi <= mtime_ext[63:32];

      rvalid_o <= req_i;
      err_o    <= req_i & ~hit;
      rdata_o  <= (rd_en && hit) ? rd_mux : '0;
    end
  end

  always_comb begin
    cfg_rd = '0;
    cfg_rd[PrescaleWidth-1:0]         = prescale;
    cfg_rd[CfgStepLsb +: StepWidth]   = step;
  end

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      RegCtrl:    rd_mux = {31'd0, active};
      RegCfg:     rd_mux = cfg_rd;
      RegMtimeLo: rd_mux = mtime_ext[31:0];
      RegMtimeHi: rd_mux = shadow_hi;
      default: begin
        for (int h = 0; h < NumHarts; h++)
          if (int'(hart_idx) == h) rd_mux = ch_rdata[h];
      end
    endcase
  end

  for (genvar h = 0; h < NumHarts; h++) begin : g_ch
    timer_hart_channel #(
      .CounterWidth(CounterWidth)
    ) u_ch (
      .clk    (clk_i),
      .rst    (rst_i),
      .mtime  (mtime),
      .wr     (ch_wr[h]),
      .wdata  (wdata_i),
      .rd_off (5'(ch_off)),
      .rdata  (ch_rdata[h]),
      .irq    (irq_o[h])
    );
  end

endmodule
